// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multi-cycle unit: SELECT codes (common with
// the ALU), FSM state encoding and the default datapath width.
package muldiv_unit_pkg;
   localparam int XLEN_DEF = 32;

   localparam logic [4:0] SEL_MUL    = 5'b01000;
   localparam logic [4:0] SEL_MULH   = 5'b01001;
   localparam logic [4:0] SEL_MULHU  = 5'b01010;
   localparam logic [4:0] SEL_MULHSU = 5'b01011;
   localparam logic [4:0] SEL_DIV    = 5'b01100;
   localparam logic [4:0] SEL_DIVU   = 5'b01101;
   localparam logic [4:0] SEL_REM    = 5'b01110;
   localparam logic [4:0] SEL_REMU   = 5'b01111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_FIN  = 2'd3
   } state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: yields operand magnitudes on the way
// in and applies the sign correction to products/quotients on the way out.
module muldiv_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res
);
   assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with a START/BUSY/DONE handshake and a held RESULT.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [4:0]      select,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);

   state_t            state;
   logic [4:0]        op;
   logic              s1, s2;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opa;

   // Operand signedness: MUL/MULH/MULHSU treat rs1 as signed, MUL/MULH rs2;
   // DIV/REM treat both as signed.
   logic is_div, sgn1, sgn2;
   assign is_div = select[2];
   assign sgn1   = is_div ? ~select[0] : (select[1:0] != 2'b10);
   assign sgn2   = is_div ? ~select[0] : ~select[1];

   logic [XLEN-1:0] mag1, mag2;
   muldiv_signfix #(.W(XLEN)) u_pre1 (.val(data1), .neg(sgn1 & data1[XLEN-1]), .res(mag1));
   muldiv_signfix #(.W(XLEN)) u_pre2 (.val(data2), .neg(sgn2 & data2[XLEN-1]), .res(mag2));

   logic dz, ovf;
   logic [XLEN-1:0] fres;
   assign dz   = (data2 == '0);
   assign ovf  = ~select[0] && (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
   // Overflow DIV returns the dividend itself (most negative value).
   assign fres = dz ? (select[1] ? data1 : '1) : (select[1] ? '0 : data1);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   dres;
   muldiv_signfix #(.W(2*XLEN)) u_postm (.val(acc), .neg(s1 ^ s2), .res(prod));
   muldiv_signfix #(.W(XLEN)) u_postd (
      .val(op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]),
      .neg(op[1] ? s1 : (s1 ^ s2)),
      .res(dres)
   );

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
   logic [XLEN:0] msum, dsh, ddif;
   assign msum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opa};
   assign dsh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign ddif = dsh - {1'b0, opa};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         op     <= '0;
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         opa    <= '0;
      end else begin
         done <= 1'b0;
         if (state != S_IDLE && flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (start && !flush && select[4:3] == 2'b01) begin
                  op   <= select;
                  s1   <= sgn1 & data1[XLEN-1];
                  s2   <= sgn2 & data2[XLEN-1];
                  cnt  <= '0;
                  busy <= 1'b1;
                  if (is_div && (dz || ovf)) begin
                     result <= fres;
                     done   <= 1'b1;
                     state  <= S_FIN;
                  end else begin
                     state <= S_CALC;
                     acc   <= {{XLEN{1'b0}}, is_div ? mag1 : mag2};
                     opa   <= is_div ? mag2 : mag1;
                  end
               end
               S_CALC: begin
                  if (op[2]) begin
                     if (!ddif[XLEN]) acc <= {ddif[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                     else             acc <= {dsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                  end else if (acc[0]) begin
                     acc <= {msum, acc[XLEN-1:1]};
                  end else begin
                     acc <= {1'b0, acc[2*XLEN-1:1]};
                  end
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(XLEN-1)) state <= S_FIX;
               end
               S_FIX: begin
                  if (op[2])              result <= dres;
                  else if (op[1:0] == 2'b00) result <= prod[XLEN-1:0];
                  else                    result <= prod[2*XLEN-1:XLEN];
                  done  <= 1'b1;
                  state <= S_FIN;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed vectors, latency, fast paths,
// flush, ignored starts, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  select = '0;
   logic [31:0] data1 = '0, data2 = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] result;

   int total = 0;
   int bad = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .select(select),
      .data1(data1), .data2(data2), .flush(flush),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one op, scramble operands after acceptance, check latency/result/pulse.
   task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int n;
      logic bz;
      @(negedge clk);
      select = sel; data1 = a; data2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; data1 = $urandom; data2 = $urandom;
      n = 0; bz = busy;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (!busy) bz = 1'b0;
      end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_res"}, result, exp);
      chk({tag, "_busy"}, {31'd0, bz}, 32'd1);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk(tag, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      int n;
      logic [31:0] prev;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_res", result, 32'd0);
      @(negedge clk); reset = 1'b1;

      run_op("mul",    5'b01000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_op("mulh",   5'b01001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhu",  5'b01010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("mulhsu", 5'b01011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_op("div",    5'b01100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem",    5'b01110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu",   5'b01101, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33);
      run_op("remu",   5'b01111, 32'd100,      32'd7,        32'd2,        33);
      run_op("div0",   5'b01100, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
      run_op("remu0",  5'b01111, 32'd5,        32'd0,        32'd5,        0);
      run_op("divovf", 5'b01100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
      run_op("removf", 5'b01110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);

      // Flush on the 10th CALC cycle.
      prev = result;
      @(negedge clk);
      select = 5'b01101; data1 = 32'd100; data2 = 32'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      watch_no_done("flush_nodone", 40);
      chk("flush_res", result, prev);

      // START while busy is ignored: a fast-path DIV poked mid-multiply.
      @(negedge clk);
      select = 5'b01000; data1 = 32'd7; data2 = 32'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         start = (n == 5);
         if (n == 5) begin select = 5'b01100; data1 = 32'd5; data2 = 32'd0; end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("bsy_lat", n, 33);
      chk("bsy_res", result, 32'd21);
      @(posedge clk); #1;
      chk("bsy_idle", {31'd0, busy}, 32'd0);

      // START held through the FIN cycle of a fast-path op is not re-accepted.
      @(negedge clk);
      select = 5'b01101; data1 = 32'd9; data2 = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      chk("fin_done", {31'd0, done}, 32'd1);
      @(posedge clk); #1; start = 1'b0;
      chk("fin_busy", {31'd0, busy}, 32'd0);
      watch_no_done("fin_nodone", 5);
      chk("fin_res", result, 32'hFFFFFFFF);

      // Illegal SELECT is ignored.
      prev = result;
      @(negedge clk);
      select = 5'b00000; data1 = 32'd3; data2 = 32'd4; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("ill_busy", {31'd0, busy}, 32'd0);
      watch_no_done("ill_nodone", 5);
      chk("ill_res", result, prev);

      // Reset pulse mid-CALC.
      @(negedge clk);
      select = 5'b01000; data1 = 32'd6; data2 = 32'd6; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b0; #1;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_done", {31'd0, done}, 32'd0);
      chk("mrst_res", result, 32'd0);
      @(negedge clk); reset = 1'b1;
      watch_no_done("mrst_nodone", 40);

      // Back-to-back issue directly after FIN.
      run_op("b2b_a", 5'b01000, 32'd1000, 32'd1000, 32'd1000000, 33);
      run_op("b2b_b", 5'b01111, 32'd1000000, 32'd999, 32'd1, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
